// File: rtl/data_register.sv
// DEPTH x DATA_WIDTH register array: one clocked write port, one combinational read port.
// Reset asynchronously clears every word.
module data_register #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] words [DEPTH];

    // Reset wins over a coincident write; otherwise only the addressed word changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (enable_write) begin
            words[write_addr] <= write_data;
        end
    end

    // No write-data bypass: a same-address write shows up only after the edge.
    assign read_data = words[read_addr];

endmodule

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed vector table, read-during-write and
// mid-cycle reset sequences, and random traffic against an array reference model.
module tb_data_register;

    logic       clock;
    logic       reset;
    logic       enable_write;
    logic [7:0] write_addr;
    logic [7:0] read_addr;
    logic [7:0] write_data;
    logic [7:0] read_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];

    typedef struct {
        logic       we;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] expected;
        string      name;
    } vec_t;

    vec_t vecs [$];

    data_register dut (
        .clock        (clock),
        .reset        (reset),
        .enable_write (enable_write),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [7:0] expected);
        checks++;
        if (read_data !== expected) begin
            errors++;
            $display("[TB] FAIL %s: read_data=%h expected=%h (read_addr=%0d)",
                     name, read_data, expected, read_addr);
        end
    endtask

    // Drive one cycle at the falling edge, let the rising edge happen, keep the model in step.
    task automatic apply_stimulus(input logic we, input logic [7:0] waddr,
                                  input logic [7:0] wdata, input logic [7:0] raddr);
        @(negedge clock);
        enable_write = we;
        write_addr   = waddr;
        write_data   = wdata;
        read_addr    = raddr;
        @(posedge clock);
        if (we && !reset) ref_mem[waddr] = wdata;
        #1;
    endtask

    task automatic add_vec(input logic we, input logic [7:0] waddr, input logic [7:0] wdata,
                           input logic [7:0] raddr, input logic [7:0] expected,
                           input string name);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.raddr = raddr; v.expected = expected; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        logic       we;
        logic [7:0] wa, wd, ra;

        add_vec(1'b0, 8'd0,   8'h00, 8'd0,   8'h00, "reset_read_0");
        add_vec(1'b0, 8'd0,   8'h00, 8'd1,   8'h00, "reset_read_1");
        add_vec(1'b0, 8'd0,   8'h00, 8'd2,   8'h00, "reset_read_2");
        add_vec(1'b0, 8'd0,   8'h00, 8'd255, 8'h00, "reset_read_255");
        add_vec(1'b1, 8'd0,   8'h04, 8'd0,   8'h04, "write_04_addr0");
        add_vec(1'b1, 8'd1,   8'h05, 8'd1,   8'h05, "write_05_addr1");
        add_vec(1'b0, 8'd2,   8'h06, 8'd0,   8'h04, "readback_addr0");
        add_vec(1'b0, 8'd2,   8'h06, 8'd1,   8'h05, "readback_addr1");
        add_vec(1'b0, 8'd2,   8'h06, 8'd2,   8'h00, "no_write_edge1");
        add_vec(1'b0, 8'd2,   8'h06, 8'd2,   8'h00, "no_write_edge2");
        add_vec(1'b1, 8'd255, 8'hFF, 8'd255, 8'hFF, "write_ff_addr255");
        add_vec(1'b1, 8'd0,   8'hAA, 8'd0,   8'hAA, "write_aa_addr0");
        add_vec(1'b0, 8'd0,   8'h00, 8'd255, 8'hFF, "readback_addr255");
        add_vec(1'b0, 8'd0,   8'h00, 8'd0,   8'hAA, "readback_addr0_aa");
        add_vec(1'b0, 8'd0,   8'h00, 8'd1,   8'h05, "addr1_still_05");
        add_vec(1'b1, 8'd9,   8'h11, 8'd9,   8'h11, "consec_write_a");
        add_vec(1'b1, 8'd9,   8'h22, 8'd9,   8'h22, "consec_write_b");

        clear_model();
        reset        = 1'b1;
        enable_write = 1'b0;
        write_addr   = 8'd0;
        write_data   = 8'h00;
        read_addr    = 8'd0;
        #1;
        check_output("reset_held", 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
            check_output(vecs[i].name, vecs[i].expected);
        end

        $display("[TB] read-during-write sequence");
        @(negedge clock);
        enable_write = 1'b1;
        write_addr   = 8'd3;
        write_data   = 8'h33;
        read_addr    = 8'd3;
        #1;
        check_output("rdw_before_edge", 8'h00);
        @(posedge clock);
        ref_mem[3] = 8'h33;
        #1;
        check_output("rdw_after_edge", 8'h33);
        @(negedge clock);
        enable_write = 1'b0;
        read_addr    = 8'd0;
        #1;
        check_output("comb_read_follow", 8'hAA);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            wd = 8'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? wa : 8'($urandom_range(0, 7));
            @(negedge clock);
            enable_write = we;
            write_addr   = wa;
            write_data   = wd;
            read_addr    = ra;
            #1;
            check_output("rand_before_edge", ref_mem[ra]);
            @(posedge clock);
            if (we) ref_mem[wa] = wd;
            #1;
            check_output("rand_after_edge", ref_mem[ra]);
            read_addr = 8'($urandom_range(0, 7));
            #1;
            check_output("rand_addr_change", ref_mem[read_addr]);
        end

        $display("[TB] mid-cycle reset sequence");
        apply_stimulus(1'b1, 8'd255, 8'hFF, 8'd255);
        check_output("pre_reset_value", 8'hFF);
        @(posedge clock);
        #3;
        reset = 1'b1;
        clear_model();
        #1;
        check_output("reset_immediate", 8'h00);
        for (int k = 0; k < 8; k++) begin
            read_addr = 8'($urandom_range(0, 7));
            #1;
            check_output("reset_all_clear", 8'h00);
        end
        @(negedge clock);
        enable_write = 1'b1;
        write_addr   = 8'd5;
        write_data   = 8'h5A;
        read_addr    = 8'd5;
        @(posedge clock);
        #1;
        check_output("write_during_reset", 8'h00);
        @(negedge clock);
        reset        = 1'b0;
        enable_write = 1'b0;
        #1;
        check_output("write_discarded", 8'h00);
        apply_stimulus(1'b1, 8'd0, 8'h07, 8'd0);
        check_output("first_write_after_reset", 8'h07);
        read_addr = 8'd5;
        #1;
        check_output("addr5_still_clear", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_register.md
DATA_REGISTER -- requirements
Module: data_register

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of each storage word and of write_data/read_data.
REQ-002 Parameter: ADDR_WIDTH, default 8, width of write_addr/read_addr.
REQ-003 Parameter: DEPTH, default 256 (2**ADDR_WIDTH), number of storage words.
REQ-004 Port: clock  input  1  single clock; all writes occur on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: enable_write  input  1  write enable, sampled on rising clock edge.
REQ-007 Port: write_addr  input  ADDR_WIDTH  word address for writes.
REQ-008 Port: read_addr  input  ADDR_WIDTH  word address for reads.
REQ-009 Port: write_data  input  DATA_WIDTH  data to store.
REQ-010 Port: read_data  output  DATA_WIDTH  word currently addressed by read_addr.
REQ-011 The block SHALL have one clock domain (clock), and reset SHALL be asynchronous and active-high.

Function
REQ-012 The block SHALL implement a DEPTH x DATA_WIDTH register array with one write port and one independent read port.
REQ-013 On a rising clock edge with reset low and enable_write=1, word[write_addr] SHALL take write_data.
REQ-014 When enable_write=0, no word SHALL change, regardless of write_addr/write_data.
REQ-015 Only the addressed word SHALL change on a write; all other words SHALL hold their value.
REQ-016 Reads SHALL be combinational: read_data = word[read_addr], zero-cycle latency, and SHALL follow read_addr changes without a clock edge.
REQ-017 A written value SHALL be visible on read_data in the same cycle, immediately after the rising edge that stores it, when read_addr equals that write_addr.
REQ-018 Read-during-write to the same address SHALL return the old word before the edge and the new word after it (no write-data bypass).
REQ-019 Consecutive writes to the same address SHALL leave the last written value.
REQ-020 Address extremes 0 and DEPTH-1 SHALL be fully usable; no wrap-around or out-of-range behaviour exists because DEPTH = 2**ADDR_WIDTH.
REQ-021 If read_addr or any bit of it is X/Z, read_data MAY be X; the block SHALL NOT add X-masking logic.

Reset
REQ-022 While reset is high, all DEPTH words SHALL be 0, and therefore read_data SHALL be 0 for every read_addr.
REQ-023 Reset SHALL take effect immediately on assertion, without waiting for a clock edge.
REQ-024 Reset SHALL override enable_write: a write coinciding with reset high SHALL be discarded.
REQ-025 After reset is released, the first rising clock edge SHALL accept writes normally.
REQ-026 Reset asserted between writes SHALL clear all previously written data.

Verification
REQ-027 Pulse reset, then drive read_addr = 0, 1, 2, 255 -> read_data = 0x00 at each address.
REQ-028 With enable_write=1, write 0x04 to address 0 and then 0x05 to address 1; set read_addr=0 -> read_data = 0x04; set read_addr=1 -> read_data = 0x05.
REQ-029 With enable_write=0, drive write_addr=2 and write_data=0x06 for 2 edges; read_addr=2 -> read_data = 0x00.
REQ-030 Write 0xFF to address 255 and 0xAA to address 0, then read both -> 0xFF and 0xAA; address 1 still holds 0x05.
REQ-031 Hold read_addr=3 while writing 0x33 to address 3 -> read_data = old value (0x00) before the edge and 0x33 after the edge.
REQ-032 Assert reset mid-cycle (not on an edge) after the writes above -> read_data drops to 0x00 at once; a write with reset high is ignored; after reset release, writing 0x07 to address 0 reads back 0x07.
